button_cond: RTL and testbench

- Conditions one raw push-button (adv_hr or adv_min) for the digital clock.
- Synchronises the asynchronous pin into clk, debounces it, and emits a single-cycle advance pulse per press, with optional auto-repeat while the button is held.
- Sits directly upstream of dig_clock_top. Two instances are used, one per advance button, and each pulse output drives adv_hr or adv_min.

---
 rtl/button_cond.sv | 141 ++++++++++++++
 tb/tb_button_cond.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/button_cond.sv
// button_cond: conditions one raw advance push-button for the digital clock.
// Two-flop synchroniser, counter-based debounce, and a single-cycle advance
// strobe per press with optional auto-repeat while the button stays held.
`timescale 1ns/1ps
module button_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise, fall;
  state_e          state_q, state_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            pulse_q, pulse_d;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatching cycles; flip level on the last one.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
        rise    = sync2_q;
        fall    = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounced level and its mismatch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Press FSM: first pulse with the level edge, then delayed and periodic repeats;
  // a release always wins over a repeat that falls due in the same cycle.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rp_cnt_d = '0;
        if (rise) begin
          pulse_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d  = IDLE;
          rp_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rp_cnt_q == DELAY_LAST) begin
            pulse_d  = 1'b1;
            rp_cnt_d = '0;
            state_d  = REPEAT;
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d  = IDLE;
          rp_cnt_d = '0;
        end else if (rp_cnt_q == RATE_LAST) begin
          pulse_d  = 1'b1;
          rp_cnt_d = '0;
        end else begin
          rp_cnt_d = rp_cnt_q + RP_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        rp_cnt_d = '0;
      end
    endcase
  end

  // FSM state, repeat counter and registered strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rp_cnt_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: tb/tb_button_cond.sv
// Bench for button_cond: one repeating and one single-shot instance share the
// same button and reset; a window/timing model predicts every cycle.
`timescale 1ns/1ps
module tb_button_cond;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic lvl_r, pls_r, lvl_n, pls_n;

  always #5 clk = ~clk;

  button_cond #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_r (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(lvl_r), .pulse(pls_r));

  button_cond #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_n (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(lvl_n), .pulse(pls_n));

  typedef struct {
    logic lvl;
    logic pr;
    logic pn;
  } exp_t;

  typedef struct {
    logic btn;
    int   len;
    logic lvl_end;
    int   np_r;
    int   np_n;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[NV];
  int   errors = 0;
  int   checks = 0;
  int   pc_r, pc_n;

  // model state: last D+1 samples of btn_in (index 0 = newest), level, edge index
  logic s_hist [0:D];
  logic m_level;
  int   m_e = 0;
  int   m_p = 0;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= D; i++) s_hist[i] = 1'b0;
    m_level = 1'b0;
  endtask

  // Level flips once the D samples taken 2..D+1 edges ago all disagree with it;
  // pulses at the rise P, at P+RD and every RR after that while level holds.
  task automatic model_edge(input logic b, output exp_t e);
    logic all_diff;
    logic nl;
    int   d;
    all_diff = 1'b1;
    for (int i = 1; i <= D; i++) if (s_hist[i] == m_level) all_diff = 1'b0;
    nl = all_diff ? ~m_level : m_level;
    e.lvl = nl;
    e.pr  = 1'b0;
    e.pn  = 1'b0;
    if (nl && !m_level) begin
      e.pr = 1'b1;
      e.pn = 1'b1;
      m_p  = m_e;
    end else if (nl && m_level) begin
      d = m_e - m_p;
      if (d == RD || (d > RD && ((d - RD) % RR) == 0)) e.pr = 1'b1;
    end
    m_level = nl;
    for (int i = D; i >= 1; i--) s_hist[i] = s_hist[i-1];
    s_hist[0] = b;
    m_e++;
  endtask

  // Drive one cycle: push the prediction, let the edge happen, pop and compare.
  task automatic step(input logic b);
    exp_t e;
    exp_t got;
    btn_in = b;
    if (rst) model_edge(b, e);
    else begin
      model_reset();
      e = '{1'b0, 1'b0, 1'b0};
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check1("level_r", lvl_r, got.lvl);
    check1("level_n", lvl_n, got.lvl);
    check1("pulse_r", pls_r, got.pr);
    check1("pulse_n", pls_n, got.pn);
    if (pls_r === 1'b1) pc_r++;
    if (pls_n === 1'b1) pc_n++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    // idle, long press with repeats, release racing a repeat, short press,
    // bounce sequence, release racing the first repeat
    vt[0]  = '{1'b0, 50, 1'b0, 0, 0};
    vt[1]  = '{1'b1, 31, 1'b1, 7, 1};
    vt[2]  = '{1'b0, 20, 1'b0, 1, 0};
    vt[3]  = '{1'b1,  8, 1'b1, 1, 1};
    vt[4]  = '{1'b0, 10, 1'b0, 0, 0};
    vt[5]  = '{1'b1,  2, 1'b0, 0, 0};
    vt[6]  = '{1'b0,  1, 1'b0, 0, 0};
    vt[7]  = '{1'b1,  3, 1'b0, 0, 0};
    vt[8]  = '{1'b0,  1, 1'b0, 0, 0};
    vt[9]  = '{1'b1, 10, 1'b1, 1, 1};
    vt[10] = '{1'b0, 10, 1'b0, 0, 0};

    rst    = 1'b1;
    btn_in = 1'b0;
    pc_r   = 0;
    pc_n   = 0;
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    check1("reset_level_r", lvl_r, 1'b0);
    check1("reset_pulse_r", pls_r, 1'b0);
    check1("reset_level_n", lvl_n, 1'b0);
    check1("reset_pulse_n", pls_n, 1'b0);
    step(1'b0);
    step(1'b0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      pc_r = 0;
      pc_n = 0;
      for (int c = 0; c < vt[i].len; c++) step(vt[i].btn);
      check1($sformatf("seg%0d_level", i), lvl_r, vt[i].lvl_end);
      check_int($sformatf("seg%0d_pulses_r", i), pc_r, vt[i].np_r);
      check_int($sformatf("seg%0d_pulses_n", i), pc_n, vt[i].np_n);
    end

    // Reset while held: press, assert reset right after the edge-21 repeat
    // pulse, release it after edge 25, and expect a fresh press at edge 31.
    for (int c = 0; c < 22; c++) step(1'b1);
    check1("pre_reset_level", lvl_r, 1'b1);
    check1("pre_reset_pulse", pls_r, 1'b1);
    rst = 1'b0;
    #1;
    check1("async_level_r", lvl_r, 1'b0);
    check1("async_pulse_r", pls_r, 1'b0);
    check1("async_level_n", lvl_n, 1'b0);
    check1("async_pulse_n", pls_n, 1'b0);
    for (int c = 22; c <= 25; c++) step(1'b1);
    rst   = 1'b1;
    first = -1;
    pc_r  = 0;
    pc_n  = 0;
    for (int c = 26; c <= 60; c++) begin
      step(1'b1);
      if (first < 0 && lvl_r === 1'b1) first = c;
    end
    check_int("rerise_edge", first, 31);
    // pulses at 31, 41, 44, 47, 50, 53, 56, 59
    check_int("rerise_pulses_r", pc_r, 8);
    check_int("rerise_pulses_n", pc_n, 1);
    for (int c = 0; c < 12; c++) step(1'b0);
    check1("final_level", lvl_r, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
